// File: rtl/ram_sync_pkg.sv
// Shared types, defaults and byte-merge helper for the sync dual-port RAM family.
// Latency: none (types and a pure combinational function only).
// Backpressure: not applicable.
package ram_sync_pkg;

  typedef enum logic {INIT, READY} ram_clr_state_t;

  localparam int RAM_SYNC_DEF_AWIDTH = 3;
  localparam int RAM_SYNC_DEF_DWIDTH = 32;

  // be_merge works on a fixed, generous width so any DWIDTH up to this bound
  // can use it; callers zero-extend their operands and keep the low DWIDTH bits.
  localparam int RAM_SYNC_MAX_DWIDTH = 1024;
  localparam int RAM_SYNC_MAX_BWIDTH = RAM_SYNC_MAX_DWIDTH / 8;

  // Byte-masked merge: byte i comes from new_dat where be[i] is set, else from old_dat.
  function automatic logic [RAM_SYNC_MAX_DWIDTH-1:0] be_merge(
    input logic [RAM_SYNC_MAX_DWIDTH-1:0] old_dat,
    input logic [RAM_SYNC_MAX_DWIDTH-1:0] new_dat,
    input logic [RAM_SYNC_MAX_BWIDTH-1:0] be
  );
    logic [RAM_SYNC_MAX_DWIDTH-1:0] res;
    res = old_dat;
    for (int i = 0; i < RAM_SYNC_MAX_BWIDTH; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_dat[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_sync_clr_ctrl.sv
// Post-reset clear sequencer: walks every address once emitting a zero-write strobe.
// Latency: exactly DEPTH cycles of init_busy after the last reset-high edge.
// Backpressure: none; the sweep cannot be stalled, only restarted by reset.
module ram_sync_clr_ctrl
  import ram_sync_pkg::*;
#(
  parameter int AWIDTH = RAM_SYNC_DEF_AWIDTH
) (
  input  logic              clock,
  input  logic              reset,
  output logic              clr_we,
  output logic [AWIDTH-1:0] clr_addr,
  output logic              init_busy
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  ram_clr_state_t    state;
  ram_clr_state_t    state_nxt;
  logic [AWIDTH-1:0] addr_nxt;

  // State and sweep address registers; reset always restarts the sweep at 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= addr_nxt;
    end
  end

  // Next-state and strobes: one zero-write per INIT cycle, leave after the last address.
  always_comb begin
    state_nxt = state;
    addr_nxt  = clr_addr;
    clr_we    = 1'b0;
    init_busy = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        // No memory write may happen while reset is held.
        clr_we    = !reset;
        addr_nxt  = clr_addr + 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_nxt = READY;
        end
      end
      READY: begin
        state_nxt = READY;
      end
    endcase
  end

endmodule

// File: rtl/ram_sync_dp_clr.sv
// Simple-dual-port sync RAM with byte-masked writes, write-first forwarding and hardware clear.
// Latency: 1-cycle read (2 cycles with RAM_SYNC_OUTREG_EN defined); writes visible next cycle.
// Backpressure: none; one read and one write per cycle, requests dropped while init_busy.
module ram_sync_dp_clr
  import ram_sync_pkg::*;
#(
  parameter int AWIDTH = RAM_SYNC_DEF_AWIDTH,
  parameter int DWIDTH = RAM_SYNC_DEF_DWIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AWIDTH-1:0]   wr_addr,
  input  logic [DWIDTH-1:0]   wr_data,
  input  logic [DWIDTH/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [AWIDTH-1:0]   rd_addr,
  output logic [DWIDTH-1:0]   rd_data,
  output logic                rd_valid,
  output logic                init_busy
);

  localparam int DEPTH  = 1 << AWIDTH;
  localparam int BWIDTH = DWIDTH / 8;
  localparam int MAXD   = RAM_SYNC_MAX_DWIDTH;
  localparam int MAXB   = RAM_SYNC_MAX_BWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              clr_we;
  logic [AWIDTH-1:0] clr_addr;
  logic              user_we;
  logic              user_re;

  logic [MAXD-1:0]   wr_old_w;
  logic [MAXD-1:0]   rd_old_w;
  logic [MAXD-1:0]   wr_new_w;
  logic [MAXB-1:0]   wr_be_w;
  logic [MAXB-1:0]   fwd_be_w;
  logic [MAXD-1:0]   wr_merged_w;
  logic [MAXD-1:0]   rd_merged_w;
  logic [DWIDTH-1:0] wr_merged;
  logic [DWIDTH-1:0] rd_merged;
  logic              unused_merge_hi;

  logic [DWIDTH-1:0] s1_data;
  logic              s1_valid;

  ram_sync_clr_ctrl #(
    .AWIDTH(AWIDTH)
  ) u_clr_ctrl (
    .clock     (clock),
    .reset     (reset),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  // User requests are only honoured once the clear sweep has finished.
  assign user_we = wr_en && !init_busy && !reset;
  assign user_re = rd_en && !init_busy && !reset;

  // Widen operands for the shared merge helper; forwarding only applies on a same-address write.
  always_comb begin
    wr_old_w = '0;
    rd_old_w = '0;
    wr_new_w = '0;
    wr_be_w  = '0;
    fwd_be_w = '0;
    wr_old_w[DWIDTH-1:0] = mem[wr_addr];
    rd_old_w[DWIDTH-1:0] = mem[rd_addr];
    wr_new_w[DWIDTH-1:0] = wr_data;
    wr_be_w[BWIDTH-1:0]  = wr_be;
    if (wr_en && (wr_addr == rd_addr)) begin
      fwd_be_w[BWIDTH-1:0] = wr_be;
    end
    wr_merged_w = be_merge(wr_old_w, wr_new_w, wr_be_w);
    rd_merged_w = be_merge(rd_old_w, wr_new_w, fwd_be_w);
    wr_merged   = wr_merged_w[DWIDTH-1:0];
    rd_merged   = rd_merged_w[DWIDTH-1:0];
  end

  // Bits above DWIDTH are always zero-padding; fold them away here.
  assign unused_merge_hi = ^{wr_merged_w, rd_merged_w};

  // Storage update: the clear sweep has priority over user writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else if (user_we) begin
        mem[wr_addr] <= wr_merged;
      end
    end
  end

  // First read stage: capture forwarded data, hold it when no read is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= user_re;
      if (user_re) begin
        s1_data <= rd_merged;
      end
    end
  end

`ifdef RAM_SYNC_OUTREG_EN
  logic [DWIDTH-1:0] s2_data;
  logic              s2_valid;

  // Output register stage: data is already resolved, so later writes cannot disturb it.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_data  <= s1_data;
      s2_valid <= s1_valid;
    end
  end

  assign rd_data  = s2_data;
  assign rd_valid = s2_valid;
`else
  assign rd_data  = s1_data;
  assign rd_valid = s1_valid;
`endif

endmodule

// File: tb/tb_ram_sync_dp_clr.sv
// Bench for ram_sync_dp_clr (AWIDTH=3, DWIDTH=32): directed scenarios plus randomized traffic
// against a behavioural model; honours RAM_SYNC_OUTREG_EN for the read latency.
module tb_ram_sync_dp_clr;

`ifdef RAM_SYNC_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        init_busy;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  ram_sync_dp_clr #(.AWIDTH(3), .DWIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .init_busy (init_busy)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [31:0] mmem [DEPTH];
  int          since_rst = 0;
  logic [31:0] nd, s1_d = '0, exp_data = '0;
  logic        nv, s1_v = 1'b0, exp_vld = 1'b0, exp_busy = 1'b1;

  always @(posedge clock) begin
    if (reset) begin
      since_rst = 0;
      s1_v = 1'b0; s1_d = '0;
      exp_vld = 1'b0; exp_data = '0;
    end else begin
      nv = 1'b0;
      nd = (LAT == 2) ? s1_d : exp_data;
      if (since_rst < DEPTH) begin
        mmem[since_rst] = '0;
        since_rst++;
      end else begin
        if (rd_en) begin
          nv = 1'b1;
          nd = mmem[rd_addr];
          if (wr_en && wr_addr == rd_addr)
            for (int b = 0; b < 4; b++) if (wr_be[b]) nd[8*b +: 8] = wr_data[8*b +: 8];
        end
        if (wr_en)
          for (int b = 0; b < 4; b++) if (wr_be[b]) mmem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      end
      if (LAT == 2) begin
        exp_vld = s1_v; exp_data = s1_d;
        s1_v = nv; s1_d = nd;
      end else begin
        exp_vld = nv; exp_data = nd;
      end
    end
    exp_busy = (since_rst < DEPTH);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: every cycle once the first reset has been applied.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_vld});
      chk("rd_data", rd_data, exp_data);
      chk("init_busy", {31'b0, init_busy}, {31'b0, exp_busy});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0;
  endtask

  task automatic read_chk(input logic [2:0] a, input logic [31:0] e, input string name);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (LAT - 1) step();
    chk({name, "_vld"}, {31'b0, rd_valid}, 32'd1);
    chk(name, rd_data, e);
    chk({name, "_model"}, exp_data, e);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 50 && init_busy; i++) begin
      n++;
      step();
    end
  endtask

  logic [31:0] obs_d [12];
  logic        obs_v [12];
  int          n;

  initial begin
    // Reset for two cycles, then the clear must take exactly DEPTH cycles.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk_on = 1'b1;
    count_busy(n);
    chk("busy_cycles_first", n, 32'd8);
    for (int a = 0; a < DEPTH; a++) read_chk(3'(a), 32'h0, "cleared_word");

    // Byte-masked overwrite.
    write(3'd5, 32'hDEADBEEF, 4'hF);
    write(3'd5, 32'h11223344, 4'b0101);
    read_chk(3'd5, 32'hDE22BE44, "masked_write");

    // Same-cycle collision forwards enabled bytes only.
    write(3'd3, 32'h01020304, 4'hF);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hCAFEF00D; wr_be = 4'b1100;
    read_chk(3'd3, 32'hCAFE0304, "collision");

    // Requests during INIT are ignored.
    reset = 1'b1; step(); reset = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("init_no_valid", {31'b0, rd_valid}, 32'd0);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    count_busy(n);
    chk("busy_gone", {31'b0, init_busy}, 32'd0);
    read_chk(3'd2, 32'h0, "init_write_dropped");

    // Reset pulsed mid-INIT restarts the full sweep.
    reset = 1'b1; step(); reset = 1'b0;
    repeat (4) step();
    reset = 1'b1; step(); reset = 1'b0;
    count_busy(n);
    chk("busy_cycles_restart", n, 32'd8);

    // Back-to-back reads with a one-cycle gap.
    for (int a = 0; a < DEPTH; a++) write(3'(a), 32'h10000000 + a, 4'hF);
    for (int c = 0; c < 12; c++) begin
      rd_en = (c <= 8) && (c != 4);
      rd_addr = (c < 4) ? 3'(c) : 3'(c - 1);
      step();
      obs_v[c] = rd_valid;
      obs_d[c] = rd_data;
    end
    rd_en = 1'b0;
    chk("b2b_before_gap_vld", {31'b0, obs_v[3 + LAT - 1]}, 32'd1);
    chk("b2b_before_gap", obs_d[3 + LAT - 1], 32'h10000003);
    chk("b2b_gap_vld", {31'b0, obs_v[4 + LAT - 1]}, 32'd0);
    chk("b2b_gap_hold", obs_d[4 + LAT - 1], 32'h10000003);
    chk("b2b_after_gap", obs_d[5 + LAT - 1], 32'h10000004);
    chk("b2b_last", obs_d[8 + LAT - 1], 32'h10000007);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 149) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      rd_en   = $urandom_range(0, 1);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_sync_dp_clr.md
# ram_sync_dp_clr

Parametrised simple-dual-port synchronous RAM, the next generation of the team's single-port sync-read data RAMs. Separate write and read ports operate in the same cycle. Writes are byte-masked. Reads use a valid handshake with same-address write-first forwarding. A hardware clear sequencer zeroes every word after reset, so contents no longer depend on a preload file. It sits between datapath engines and local data storage wherever a deterministic post-reset image is required.

## Interface
- AWIDTH, 3, address width; DEPTH = 1 << AWIDTH (localparam)
- DWIDTH, 32, data width; must be a multiple of 8
- BWIDTH, DWIDTH/8 (localparam), byte-enable width
- clock  in  1  sole clock, all logic on posedge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- wr_en  in  1  write request
- wr_addr  in  AWIDTH  write address
- wr_data  in  DWIDTH  write data
- wr_be  in  BWIDTH  byte enables; bit i covers wr_data[8i+7:8i]
- rd_en  in  1  read request
- rd_addr  in  AWIDTH  read address
- rd_data  out  DWIDTH  read data, held between reads
- rd_valid  out  1  one-cycle pulse, rd_data is new
- init_busy  out  1  clear sequence in progress; requests ignored

## Operation
- FSM states are INIT and READY.
- reset high:
  - state goes to INIT and clr_addr to 0.
  - rd_valid=0, rd_data=0, init_busy=1.
  - Memory is not written while reset is high.
- INIT behaviour:
  - Each cycle with reset low writes all-zero to mem[clr_addr], then clr_addr increments.
  - When clr_addr == DEPTH-1 is written, the next state is READY and init_busy falls.
  - INIT lasts exactly DEPTH cycles after reset deasserts.
  - wr_en and rd_en are ignored; rd_valid stays 0.
- READY, write: if wr_en, for each i with wr_be[i]=1, mem[wr_addr] byte i <= wr_data byte i. Other bytes are unchanged. wr_be=0 is a no-op.
- READY, read: if rd_en, rd_data <= mem[rd_addr] and rd_valid=1 on the next edge.
- Collision (rd_en && wr_en && rd_addr==wr_addr in the same cycle): write-first per byte.
  - Enabled bytes come from wr_data.
  - Disabled bytes come from the old mem contents.
- rd_en low: rd_valid=0 and rd_data holds its last value.
- reset asserted mid-INIT: the sweep restarts from address 0.
- reset asserted in READY: contents are re-cleared by the new INIT.
- The clear is not interruptible except by reset.

## Timing
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_data/rd_valid at edge N+1.
- Write latency: mem is updated at edge N. A read issued at edge N+1 sees the new data. A same-cycle read sees it via forwarding.
- Throughput is one read and one write per cycle, fully pipelined, with no back-pressure.
- init_busy falls at edge DEPTH after the last reset-high edge. A request issued in that same cycle is accepted.
- Reset values: rd_data=0, rd_valid=0, init_busy=1.

## Configuration
- RAM_SYNC_OUTREG_EN defined:
  - Adds an output register stage; read latency becomes 2 cycles.
  - rd_data/rd_valid come from the second stage.
  - Forwarding is resolved in stage 1. A write at edge N+1 to an address read at edge N does not alter the in-flight data.
  - reset also clears stage-2 data/valid to 0.
- Not defined: 1-cycle latency as described above.

## Structure
- Package ram_sync_pkg holds:
  - typedef enum logic {INIT, READY} ram_clr_state_t
  - constant RAM_SYNC_DEF_AWIDTH = 3
  - constant RAM_SYNC_DEF_DWIDTH = 32
  - function be_merge(old, new, be), the byte-masked merge used for both writes and forwarding
- One sub-module, ram_sync_clr_ctrl:
  - Contains the FSM and the clr_addr counter.
  - Outputs clr_we, clr_addr, init_busy.
  - The top muxes clear writes over user writes.

## Test plan (AWIDTH=3, DWIDTH=32)
- Reset 2 cycles, then idle: init_busy=1 for exactly 8 cycles after reset falls. Reading all addresses then returns 0x00000000 with rd_valid each time.
- Write 0xDEADBEEF at addr 5 with be=4'hF, then write 0x11223344 at addr 5 with be=4'b0101 -> read addr 5 returns 0xDE22BE44 one cycle after rd_en (two with RAM_SYNC_OUTREG_EN).
- Same-cycle write 0xCAFEF00D at addr 3 (be=4'b1100) and read addr 3, where addr 3 held 0x01020304 -> rd_data=0xCAFE0304.
- rd_en and wr_en asserted during INIT at addr 2 with 0xFFFFFFFF -> no rd_valid. Addr 2 reads 0 after init_busy falls.
- Reset pulsed at INIT cycle 4 -> init_busy stays high for a full 8 cycles after the second reset.
- Back-to-back reads of addresses 0..7 every cycle, with rd_en dropped for one cycle mid-stream -> rd_valid shows the matching gap and rd_data holds the previous value during the gap.
